snake_move_ctrl: RTL and testbench

SNAKE_MOVE_CTRL -- requirements
Module: snake_move_ctrl

---
 rtl/snake_move_ctrl.sv | 199 +++++++++++++++++++
 tb/tb_snake_move_ctrl.sv | 336 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/snake_move_ctrl.sv
// snake_move_ctrl: game-state FSM and step timer for a snake game.
// It paces the snake with a programmable step period, buffers player turns
// in a small queue, and applies one queued turn on each step.
module snake_move_ctrl #(
  parameter int unsigned BASE_PERIOD = 12_500_000,
  parameter int unsigned FIFO_DEPTH  = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        pause,
  input  logic        collide,
  input  logic [3:0]  direc_in,
  input  logic        direc_valid,
  input  logic [1:0]  speed_sel,
  output logic        step,
  output logic [3:0]  head_dir,
  output logic [1:0]  state,
  output logic        fifo_full,
  output logic [15:0] step_cnt
);

  // FIFO_DEPTH is a power of two (2..8), so the pointers wrap naturally and
  // occupancy needs one extra bit to represent a completely full queue.
  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned OCC_W = PTR_W + 1;

  localparam logic [23:0]      BASE  = 24'(BASE_PERIOD);
  localparam logic [OCC_W-1:0] DEPTH = OCC_W'(FIFO_DEPTH);

  localparam logic [3:0] DIR_UP = 4'b1000;

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_RUN   = 2'b01,
    S_PAUSE = 2'b10,
    S_OVER  = 2'b11
  } state_e;

  state_e           state_q, state_d;
  logic [23:0]      cnt_q, cnt_d;
  logic [23:0]      period_q, period_d;
  logic             step_q, step_d;
  logic [3:0]       head_q, head_d;
  logic [3:0]       fifo_q [FIFO_DEPTH];
  logic [3:0]       fifo_d [FIFO_DEPTH];
  logic [PTR_W-1:0] rd_q, rd_d;
  logic [PTR_W-1:0] wr_q, wr_d;
  logic [OCC_W-1:0] occ_q, occ_d;
  logic [15:0]      step_cnt_q, step_cnt_d;

  logic             queue_empty;
  logic             queue_full;
  logic [3:0]       newest;
  logic [3:0]       ref_dir;
  logic             dir_onehot;
  logic             counting;
  logic             wrap;
  logic             push;
  logic             pop;
  logic [23:0]      sel_period;

  // Reversing into the body is never a legal turn: swap up/down and left/right.
  function automatic logic [3:0] opposite(input logic [3:0] d);
    return {d[2], d[3], d[0], d[1]};
  endfunction

  assign sel_period  = BASE >> speed_sel;
  assign queue_empty = (occ_q == '0);
  assign queue_full  = (occ_q == DEPTH);
  assign newest      = fifo_q[wr_q - PTR_W'(1)];
  assign ref_dir     = queue_empty ? head_q : newest;
  assign dir_onehot  = $onehot(direc_in);

  // The period counter only advances in RUN when no state change is
  // requested, so a pause or collide cycle freezes it and never steps.
  assign counting = (state_q == S_RUN) && !collide && !pause;
  assign wrap     = counting && (cnt_q == period_q - 24'd1);
  assign pop      = wrap && !queue_empty;

  // A turn is judged against the newest queued turn (or the live heading),
  // before any pop on this same edge.
  assign push = (state_q == S_RUN) && direc_valid && dir_onehot &&
                (direc_in != ref_dir) && (direc_in != opposite(ref_dir)) &&
                !queue_full;

  // Next-state logic: FSM transitions, step timing and turn-queue updates.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    period_d   = period_q;
    step_d     = 1'b0;
    head_d     = head_q;
    fifo_d     = fifo_q;
    rd_d       = rd_q;
    wr_d       = wr_q;
    occ_d      = occ_q;
    step_cnt_d = step_cnt_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d  = S_RUN;
          cnt_d    = '0;
          period_d = sel_period;
        end
      end
      S_RUN: begin
        if (collide) begin
          state_d = S_OVER;
        end else if (pause) begin
          state_d = S_PAUSE;
        end else if (wrap) begin
          cnt_d    = '0;
          period_d = sel_period;
          step_d   = 1'b1;
          if (step_cnt_q != 16'hFFFF) begin
            step_cnt_d = step_cnt_q + 16'd1;
          end
        end else begin
          cnt_d = cnt_q + 24'd1;
        end
      end
      S_PAUSE: begin
        if (collide) begin
          state_d = S_OVER;
        end else if (pause) begin
          state_d = S_RUN;
        end
      end
      S_OVER: begin
        if (start) begin
          state_d    = S_IDLE;
          cnt_d      = '0;
          head_d     = DIR_UP;
          rd_d       = '0;
          wr_d       = '0;
          occ_d      = '0;
          step_cnt_d = '0;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (pop) begin
      head_d = fifo_q[rd_q];
      rd_d   = rd_q + PTR_W'(1);
    end

    if (push) begin
      fifo_d[wr_q] = direc_in;
      wr_d         = wr_q + PTR_W'(1);
    end

    if (push && !pop) begin
      occ_d = occ_q + OCC_W'(1);
    end else if (pop && !push) begin
      occ_d = occ_q - OCC_W'(1);
    end
  end

  // State registers; reset returns everything to the idle, empty-queue state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      period_q   <= BASE;
      step_q     <= 1'b0;
      head_q     <= DIR_UP;
      rd_q       <= '0;
      wr_q       <= '0;
      occ_q      <= '0;
      step_cnt_q <= '0;
      for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
        fifo_q[i] <= '0;
      end
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      period_q   <= period_d;
      step_q     <= step_d;
      head_q     <= head_d;
      rd_q       <= rd_d;
      wr_q       <= wr_d;
      occ_q      <= occ_d;
      step_cnt_q <= step_cnt_d;
      fifo_q     <= fifo_d;
    end
  end

  assign step      = step_q;
  assign head_dir  = head_q;
  assign state     = state_q;
  assign fifo_full = queue_full;
  assign step_cnt  = step_cnt_q;

endmodule

// File: tb/tb_snake_move_ctrl.sv
// tb_snake_move_ctrl: directed scenarios plus randomized play for
// snake_move_ctrl, checked every cycle against a queue-based game model.
module tb_snake_move_ctrl;

  localparam int unsigned BASE  = 16;
  localparam int unsigned DEPTH = 4;

  localparam int ST_IDLE  = 0;
  localparam int ST_RUN   = 1;
  localparam int ST_PAUSE = 2;
  localparam int ST_OVER  = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        pause = 1'b0;
  logic        collide = 1'b0;
  logic [3:0]  direcIn = 4'b0000;
  logic        direcValid = 1'b0;
  logic [1:0]  speedSel = 2'd0;
  logic        step;
  logic [3:0]  headDir;
  logic [1:0]  state;
  logic        fifoFull;
  logic [15:0] stepCnt;

  int totalChecks = 0;
  int badChecks   = 0;

  // Reference model of the game: state name, cycles left until the next
  // step, current heading, pending turns and number of steps taken.
  int         mState;
  int         mLeft;
  int         mStepCnt;
  logic [3:0] mHead;
  logic       mStep;
  logic [3:0] mQ[$];

  snake_move_ctrl #(
    .BASE_PERIOD(BASE),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .pause      (pause),
    .collide    (collide),
    .direc_in   (direcIn),
    .direc_valid(direcValid),
    .speed_sel  (speedSel),
    .step       (step),
    .head_dir   (headDir),
    .state      (state),
    .fifo_full  (fifoFull),
    .step_cnt   (stepCnt)
  );

  // Free-running 10-unit clock.
  always #5 clk = ~clk;

  // Guard against a hung run.
  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog expired total=%0d bad=%0d", totalChecks, badChecks);
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string tag, input logic [15:0] got, input logic [15:0] exp);
    totalChecks++;
    if (got !== exp) begin
      badChecks++;
      $display("[TB] FAIL %s got=%0h expected=%0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [3:0] oppositeOf(input logic [3:0] d);
    case (d)
      4'b1000: return 4'b0100;
      4'b0100: return 4'b1000;
      4'b0010: return 4'b0001;
      4'b0001: return 4'b0010;
      default: return 4'b0000;
    endcase
  endfunction

  task automatic modelReset();
    mState   = ST_IDLE;
    mLeft    = 0;
    mStepCnt = 0;
    mHead    = 4'b1000;
    mStep    = 1'b0;
    mQ.delete();
  endtask

  // Advance the model by one clock edge using the inputs currently applied.
  task automatic modelEdge();
    logic [3:0] refDir;
    bit         doPush;
    doPush = 1'b0;
    mStep  = 1'b0;
    if (mState == ST_RUN && direcValid && $countones(direcIn) == 1 && mQ.size() < int'(DEPTH)) begin
      refDir = (mQ.size() > 0) ? mQ[mQ.size()-1] : mHead;
      if (direcIn != refDir && direcIn != oppositeOf(refDir)) doPush = 1'b1;
    end
    case (mState)
      ST_IDLE: begin
        if (start) begin
          mState = ST_RUN;
          mLeft  = int'(BASE >> speedSel);
        end
      end
      ST_RUN: begin
        if (collide) mState = ST_OVER;
        else if (pause) mState = ST_PAUSE;
        else begin
          mLeft = mLeft - 1;
          if (mLeft == 0) begin
            mStep = 1'b1;
            mLeft = int'(BASE >> speedSel);
            if (mStepCnt < 65535) mStepCnt++;
            if (mQ.size() > 0) mHead = mQ.pop_front();
          end
        end
      end
      ST_PAUSE: begin
        if (collide) mState = ST_OVER;
        else if (pause) mState = ST_RUN;
      end
      default: begin
        if (start) begin
          mState   = ST_IDLE;
          mHead    = 4'b1000;
          mStepCnt = 0;
          mLeft    = 0;
          mQ.delete();
        end
      end
    endcase
    if (doPush) mQ.push_back(direcIn);
  endtask

  task automatic compareAll();
    checkOutput("state", 16'(state), 16'(mState));
    checkOutput("step", 16'(step), 16'(mStep));
    checkOutput("head_dir", 16'(headDir), 16'(mHead));
    checkOutput("fifo_full", 16'(fifoFull), 16'(mQ.size() == int'(DEPTH)));
    checkOutput("step_cnt", stepCnt, 16'(mStepCnt));
  endtask

  task automatic tick();
    @(posedge clk);
    modelEdge();
    #1;
    compareAll();
  endtask

  task automatic applyStimulus(input bit st, input bit pa, input bit co,
                               input bit dv, input logic [3:0] dir);
    start      = st;
    pause      = pa;
    collide    = co;
    direcValid = dv;
    direcIn    = dir;
    tick();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 4'b0000);
  endtask

  task automatic waitForStep(input string tag);
    int n;
    n = 0;
    do begin
      idle(1);
      n++;
    end while (step !== 1'b1 && n < 40);
    checkOutput({tag, "_step_seen"}, 16'(step), 16'd1);
  endtask

  // Reset asserted between edges must take effect without a clock.
  task automatic doReset();
    start = 1'b0; pause = 1'b0; collide = 1'b0; direcValid = 1'b0; direcIn = 4'b0000;
    #2;
    rst = 1'b0;
    #1;
    checkOutput("rst_state", 16'(state), 16'd0);
    checkOutput("rst_step", 16'(step), 16'd0);
    checkOutput("rst_head", 16'(headDir), 16'b1000);
    checkOutput("rst_stepcnt", stepCnt, 16'd0);
    checkOutput("rst_full", 16'(fifoFull), 16'd0);
    modelReset();
    @(posedge clk);
    #1;
    compareAll();
    #2;
    rst = 1'b1;
  endtask

  initial begin
    logic [3:0] drainOrder [4];
    int         stepPos[$];
    int         r;
    bit         st, pa, co, dv;
    logic [3:0] dir;

    modelReset();
    @(posedge clk);
    #1;
    compareAll();
    #2;
    rst = 1'b1;

    // Step timing from start: period 8 (BASE 16 >> 1), steps 8, 16, 24 cycles after start.
    speedSel = 2'd1;
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 4'b0000);
    for (int k = 1; k <= 24; k++) begin
      idle(1);
      if (k % 8 == 0) begin
        checkOutput("d1_step", 16'(step), 16'd1);
        checkOutput("d1_stepcnt", stepCnt, 16'(k / 8));
        checkOutput("d1_head", 16'(headDir), 16'b1000);
      end else begin
        checkOutput("d1_nostep", 16'(step), 16'd0);
      end
    end

    // Opposite turn dropped, repeated turn dropped, accepted turn applied on step.
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 4'b0100);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 4'b0010);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 4'b0010);
    waitForStep("d2");
    checkOutput("d2_head", 16'(headDir), 16'b0010);
    waitForStep("d2b");
    checkOutput("d2_head_single", 16'(headDir), 16'b0010);

    // Fill the queue, overflow dropped, drain in order.
    doReset();
    speedSel = 2'd1;
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 4'b0000);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 4'b0010);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 4'b1000);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 4'b0001);
    checkOutput("d3_not_full", 16'(fifoFull), 16'd0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 4'b0100);
    checkOutput("d3_full", 16'(fifoFull), 16'd1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 4'b1000);
    checkOutput("d3_full_after_drop", 16'(fifoFull), 16'd1);
    drainOrder = '{4'b0010, 4'b1000, 4'b0001, 4'b0100};
    for (int i = 0; i < 4; i++) begin
      waitForStep("d3");
      checkOutput("d3_drain", 16'(headDir), 16'(drainOrder[i]));
      checkOutput("d3_full_drain", 16'(fifoFull), 16'd0);
    end

    // Pause at counter 5, hold 20 cycles, resume: step 3 cycles later.
    doReset();
    speedSel = 2'd1;
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 4'b0000);
    idle(5);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 4'b0000);
    checkOutput("d4_paused", 16'(state), 16'd2);
    idle(20);
    checkOutput("d4_still_paused", 16'(state), 16'd2);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 4'b0000);
    checkOutput("d4_resumed", 16'(state), 16'd1);
    idle(1);
    checkOutput("d4_resume1", 16'(step), 16'd0);
    idle(1);
    checkOutput("d4_resume2", 16'(step), 16'd0);
    idle(1);
    checkOutput("d4_resume3", 16'(step), 16'd1);
    // Collide on the cycle a step is due.
    idle(7);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 4'b0000);
    checkOutput("d4_over", 16'(state), 16'd3);
    checkOutput("d4_collide_nostep", 16'(step), 16'd0);
    idle(10);
    checkOutput("d4_over_hold", 16'(state), 16'd3);
    checkOutput("d4_over_stepcnt", stepCnt, 16'd1);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 4'b0000);
    checkOutput("d4_back_idle", 16'(state), 16'd0);
    checkOutput("d4_idle_stepcnt", stepCnt, 16'd0);

    // Speed change mid-period: current period 16, later periods 4.
    doReset();
    speedSel = 2'd0;
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 4'b0000);
    idle(5);
    speedSel = 2'd2;
    for (int k = 6; k <= 30; k++) begin
      idle(1);
      if (step === 1'b1) stepPos.push_back(k);
    end
    checkOutput("d5_nsteps", 16'(stepPos.size()), 16'd4);
    for (int i = 0; i < 4; i++) begin
      checkOutput("d5_pos", 16'((i < stepPos.size()) ? stepPos[i] : 0), 16'(16 + 4 * i));
    end

    // Reset mid-run with two pending turns.
    doReset();
    speedSel = 2'd1;
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 4'b0000);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 4'b0010);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 4'b1000);
    idle(2);
    checkOutput("d6_running", 16'(state), 16'd1);
    doReset();
    idle(12);
    checkOutput("d6_wait_start", 16'(state), 16'd0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 4'b0000);
    waitForStep("d6");
    checkOutput("d6_head", 16'(headDir), 16'b1000);
    waitForStep("d6b");
    checkOutput("d6_head2", 16'(headDir), 16'b1000);

    // Randomized play against the model.
    doReset();
    for (int c = 0; c < 3000; c++) begin
      r  = int'($urandom_range(0, 99));
      st = (r < 4);
      pa = ($urandom_range(0, 99) < 3);
      co = ($urandom_range(0, 199) < 2);
      dv = ($urandom_range(0, 99) < 35);
      if ($urandom_range(0, 9) < 8) dir = 4'b0001 << $urandom_range(0, 3);
      else dir = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 99) < 3) speedSel = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 999) < 3) doReset();
      else applyStimulus(st, pa, co, dv, dir);
    end

    $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
    $finish;
  end

endmodule
